sevenseg_reader: RTL and testbench

Observer for a 7-segment display bus: samples the raw `seg` pattern produced by a segment driver, waits for it to settle, and decodes it back to the 4-bit display code. It sits on the opposite side of the display interface from `sevenseg_driver`. Typical uses are a chained tile reading a neighbour's display and an on-chip self-check of the game multiplexer. Each stable change is reported as a single event over a valid/ready handshake.

---
 rtl/sevenseg_reader.sv | 215 +++++++++++++++++++++
 tb/tb_sevenseg_reader.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sevenseg_reader.sv
// sevenseg_reader: debounces a raw 7-segment bus, decodes it back to a 4-bit
// display code and reports every stable change as one valid/ready event.
// Optional input synchronizer: define SEVENSEG_READER_SYNC_EN (two-flop, L=2).
`timescale 1ns/1ps
module sevenseg_reader #(
  parameter int unsigned STABLE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg_in,
  output logic [3:0] value,
  output logic       value_valid,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [3:0] evt_code,
  output logic       evt_err,
  output logic       overflow
);

  localparam logic [7:0] STABLE_N = 8'(STABLE_CYCLES);

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_STABLE = 2'd2
  } state_e;

  typedef struct packed {
    logic       legal;
    logic [3:0] code;
  } decode_t;

  function automatic decode_t decode(input logic [6:0] pat);
    decode_t d;
    d.legal = 1'b1;
    case (pat)
      7'h3F:   d.code = 4'd0;
      7'h06:   d.code = 4'd1;
      7'h5B:   d.code = 4'd2;
      7'h4F:   d.code = 4'd3;
      7'h66:   d.code = 4'd4;
      7'h6D:   d.code = 4'd5;
      7'h7D:   d.code = 4'd6;
      7'h07:   d.code = 4'd7;
      7'h7F:   d.code = 4'd8;
      7'h6F:   d.code = 4'd9;
      7'h00:   d.code = 4'd12;
      default: begin
        d.legal = 1'b0;
        d.code  = 4'hF;
      end
    endcase
    return d;
  endfunction

  // ---------------------------------------------------------------------------
  // Sample path
  // ---------------------------------------------------------------------------
  logic [6:0] sample;
  logic       sample_ok;

`ifdef SEVENSEG_READER_SYNC_EN
  logic [6:0] sync1_q, sync2_q;
  logic [1:0] sync_vld_q;

  // The valid shift keeps the reset zeros in the synchronizer from being
  // counted as a sampled blank bus, so latency is L=2 from the first edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      sync_vld_q <= '0;
    end else begin
      sync1_q    <= seg_in;
      sync2_q    <= sync1_q;
      sync_vld_q <= {sync_vld_q[0], 1'b1};
    end
  end

  assign sample    = sync2_q;
  assign sample_ok = sync_vld_q[1];
`else
  assign sample    = seg_in;
  assign sample_ok = 1'b1;
`endif

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e     state_q, state_d;
  logic [6:0] cand_q, cand_d;
  logic [7:0] cnt_q, cnt_d;
  logic [6:0] committed_q, committed_d;
  logic       have_commit_q, have_commit_d;
  logic [3:0] value_q, value_d;
  logic       value_valid_q, value_valid_d;
  logic       evt_valid_q, evt_valid_d;
  logic [3:0] evt_code_q, evt_code_d;
  logic       evt_err_q, evt_err_d;
  logic       overflow_q, overflow_d;

  logic       mismatch;
  logic       commit;
  logic       new_evt;
  decode_t    dec;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its inputs, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_WAIT;
      cand_q        <= 7'h00;
      cnt_q         <= 8'd0;
      committed_q   <= 7'h00;
      have_commit_q <= 1'b0;
      value_q       <= 4'd12;
      value_valid_q <= 1'b0;
      evt_valid_q   <= 1'b0;
      evt_code_q    <= 4'd0;
      evt_err_q     <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cand_q        <= cand_d;
      cnt_q         <= cnt_d;
      committed_q   <= committed_d;
      have_commit_q <= have_commit_d;
      value_q       <= value_d;
      value_valid_q <= value_valid_d;
      evt_valid_q   <= evt_valid_d;
      evt_code_q    <= evt_code_d;
      evt_err_q     <= evt_err_d;
      overflow_q    <= overflow_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  assign mismatch = sample_ok && (sample != cand_q);

  // WAIT is left only by a commit; a disturbed STABLE pattern restarts settling.
  always_comb begin
    state_d = state_q;
    if (commit) begin
      state_d = ST_STABLE;
    end else if (mismatch && state_q == ST_STABLE) begin
      state_d = ST_SETTLE;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath / output logic
  // ---------------------------------------------------------------------------
  // NOTE: every variable driven here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    commit = 1'b0;
    if (sample_ok) begin
      if (mismatch) begin
        cand_d = sample;
        cnt_d  = 8'd1;
      end else if (state_q != ST_STABLE) begin
        cnt_d  = cnt_q + 8'd1;
      end
      // A load counts as the first stable sample, so STABLE_CYCLES=1 commits at once.
      commit = (mismatch || state_q != ST_STABLE) && (cnt_d == STABLE_N);
    end
  end

  assign dec     = decode(cand_d);
  assign new_evt = commit && (!have_commit_q || cand_d != committed_q);

  always_comb begin
    committed_d   = committed_q;
    have_commit_d = have_commit_q;
    value_d       = value_q;
    value_valid_d = value_valid_q;
    evt_valid_d   = evt_valid_q;
    evt_code_d    = evt_code_q;
    evt_err_d     = evt_err_q;
    overflow_d    = overflow_q;

    if (commit) begin
      committed_d   = cand_d;
      have_commit_d = 1'b1;
      value_valid_d = dec.legal;
      if (dec.legal) begin
        value_d = dec.code;
      end
    end

    // A new event wins over an accept; only an unaccepted payload is lost.
    if (new_evt) begin
      evt_valid_d = 1'b1;
      evt_code_d  = dec.code;
      evt_err_d   = !dec.legal;
      if (evt_valid_q && !evt_ready) begin
        overflow_d = 1'b1;
      end
    end else if (evt_valid_q && evt_ready) begin
      evt_valid_d = 1'b0;
    end
  end

  assign value       = value_q;
  assign value_valid = value_valid_q;
  assign evt_valid   = evt_valid_q;
  assign evt_code    = evt_code_q;
  assign evt_err     = evt_err_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_sevenseg_reader.sv
// Testbench for sevenseg_reader: random and directed segment streams checked by a
// scoreboard against a run-length reference model; a second instance covers STABLE_CYCLES=1.
`timescale 1ns/1ps
module tb_sevenseg_reader;

`ifdef SEVENSEG_READER_SYNC_EN
  localparam int L = 2;
`else
  localparam int L = 0;
`endif
  localparam int N = 16;

  localparam logic [6:0] DIGITS [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                         7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [6:0] seg_in = 7'h00;
  logic       evt_ready = 1'b0;
  logic [3:0] value, evt_code;
  logic       value_valid, evt_valid, evt_err, overflow;

  logic       rst1_n = 1'b1;
  logic [6:0] seg1 = 7'h00;
  logic       ready1 = 1'b0;
  logic [3:0] value1, evt_code1;
  logic       value_valid1, evt_valid1, evt_err1, overflow1;

  sevenseg_reader #(.STABLE_CYCLES(N)) dut (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_in),
    .value(value), .value_valid(value_valid),
    .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_code(evt_code), .evt_err(evt_err), .overflow(overflow)
  );

  sevenseg_reader #(.STABLE_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst1_n), .seg_in(seg1),
    .value(value1), .value_valid(value_valid1),
    .evt_valid(evt_valid1), .evt_ready(ready1),
    .evt_code(evt_code1), .evt_err(evt_err1), .overflow(overflow1)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: a pattern commits once it has been seen N times in a row
  // (after an L-edge delay); events are kept in an expected queue.
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [3:0] code;
    logic       err;
  } evt_t;

  evt_t       exp_q[$];
  logic [6:0] hist[$];
  int         run;
  logic [6:0] last_pat;
  logic [6:0] m_committed;
  bit         m_have, m_valid, m_pending, m_ovf;
  int         m_value;

  function automatic int ref_decode(input logic [6:0] p);
    for (int i = 0; i < 10; i++) begin
      if (DIGITS[i] == p) return i;
    end
    return (p == 7'h00) ? 12 : -1;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    hist.delete();
    run         = 0;
    last_pat    = 7'h00;
    m_committed = 7'h00;
    m_have      = 0;
    m_valid     = 0;
    m_pending   = 0;
    m_ovf       = 0;
    m_value     = 12;
  endtask

  task automatic model_step();
    logic [6:0] s;
    int         code;
    bit         new_evt, accepted;
    evt_t       e;
    new_evt  = 0;
    accepted = m_pending && evt_ready;
    hist.push_back(seg_in);
    if (hist.size() > L) begin
      s = hist.pop_front();
      if (run > 0 && s == last_pat) run++;
      else begin
        run      = 1;
        last_pat = s;
      end
      if (run == N) begin
        code    = ref_decode(s);
        new_evt = !m_have || (s != m_committed);
        m_committed = s;
        m_have      = 1;
        m_valid     = (code >= 0);
        if (code >= 0) m_value = code;
        e.code = (code >= 0) ? 4'(code) : 4'hF;
        e.err  = (code < 0);
      end
    end
    if (new_evt) begin
      if (m_pending && !accepted && exp_q.size() > 0) begin
        exp_q[exp_q.size()-1] = e;
        m_ovf = 1;
      end else begin
        exp_q.push_back(e);
      end
      m_pending = 1;
    end else if (accepted) begin
      m_pending = 0;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // Monitor: compares registered outputs mid-cycle and pops events as they are accepted.
  initial begin
    forever begin
      @(negedge clk);
      check("value", value, m_value);
      check("value_valid", value_valid, m_valid);
      check("overflow", overflow, m_ovf);
      check("evt_valid", evt_valid, m_pending);
      if (!rst_n) begin
        check("rst_evt_code", evt_code, 0);
        check("rst_evt_err", evt_err, 0);
      end else if (evt_valid) begin
        if (exp_q.size() == 0) begin
          check("evt_pending_depth", exp_q.size(), 1);
        end else begin
          check("evt_code", evt_code, exp_q[0].code);
          check("evt_err", evt_err, exp_q[0].err);
          if (evt_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  // ready_mode: 0 = low, 1 = high, 2 = random. Entered and left at posedge+1.
  task automatic hold(input logic [6:0] p, input int cycles, input int ready_mode);
    for (int i = 0; i < cycles; i++) begin
      seg_in    = p;
      evt_ready = (ready_mode == 2) ? ($urandom_range(0, 3) != 0) : (ready_mode == 1);
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [6:0] pick_pattern();
    int r;
    r = $urandom_range(0, 11);
    if (r < 10) return DIGITS[r];
    if (r == 10) return 7'h00;
    return 7'($urandom);
  endfunction

  initial begin
    logic [6:0] p;
    #1;
    rst_n  = 1'b0;
    rst1_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Blank bus after reset commits code 12 with one event.
    hold(7'h00, 20, 1);
    // 00 -> 5B with immediate accept.
    hold(7'h5B, 30, 1);
    // Short glitch to 06 and back: no event, value stays 2.
    hold(7'h06, 10, 1);
    hold(7'h5B, 30, 1);
    // Two events with no consumer: overwrite and overflow.
    hold(7'h7D, 20, 0);
    hold(7'h4F, 20, 0);
    hold(7'h4F, 3, 1);
    // Invalid patterns, each a separate error event, then a legal digit.
    hold(7'h55, 30, 1);
    hold(7'h2A, 30, 1);
    hold(7'h3F, 30, 1);

    // Reset while settling 6F at cnt=8.
    hold(7'h6F, 8 + L, 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_value", value, 12);
    check("async_rst_value_valid", value_valid, 0);
    check("async_rst_evt_valid", evt_valid, 0);
    check("async_rst_evt_code", evt_code, 0);
    check("async_rst_evt_err", evt_err, 0);
    check("async_rst_overflow", overflow, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    hold(7'h6F, 30, 1);

    // Randomized segment stream with random back-pressure.
    for (int k = 0; k < 80; k++) begin
      p = pick_pattern();
      hold(p, $urandom_range(1, 40), 2);
    end
    hold(seg_in, 40, 1);
    check("scoreboard_drained", exp_q.size(), 0);

    // STABLE_CYCLES=1 instance: 6F commits on edge L+1 after reset release.
    seg1   = 7'h6F;
    ready1 = 1'b0;
    @(posedge clk);
    #1;
    rst1_n = 1'b1;
    if (L > 0) repeat (L) @(posedge clk);
    #1;
    check("n1_pre_value", value1, 12);
    check("n1_pre_value_valid", value_valid1, 0);
    check("n1_pre_evt_valid", evt_valid1, 0);
    @(posedge clk);
    #1;
    check("n1_value", value1, 9);
    check("n1_value_valid", value_valid1, 1);
    check("n1_evt_valid", evt_valid1, 1);
    check("n1_evt_code", evt_code1, 9);
    check("n1_evt_err", evt_err1, 0);
    ready1 = 1'b1;
    @(posedge clk);
    #1;
    check("n1_evt_accepted", evt_valid1, 0);
    check("n1_overflow", overflow1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
